// File: rtl/mips.sv
// Single-cycle 32-bit MIPS subset core with instruction memory,
// register file and data memory; commit edge selectable by parameter.
module mips_imem #(
  parameter bit BYTE_IMEM = 1'b0
) (
  input  logic [7:0]  waddr_i,
  output logic [31:0] instr_o
);
  localparam int W = BYTE_IMEM ? 8 : 32;
  localparam int D = BYTE_IMEM ? 1024 : 256;

  logic [W-1:0] mem [0:D-1];

  generate
    if (BYTE_IMEM) begin : g_byte
      assign instr_o = {mem[{waddr_i, 2'd3}], mem[{waddr_i, 2'd2}],
                        mem[{waddr_i, 2'd1}], mem[{waddr_i, 2'd0}]};
    end else begin : g_word
      assign instr_o = mem[waddr_i];
    end
  endgenerate
endmodule

module mips_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] registers [0:31];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      registers[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? '0 : registers[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? '0 : registers[ra2_i];
endmodule

module mips_dmem (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o
);
  logic [31:0] mem [0:255];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (we_i) begin
      mem[addr_i] <= wd_i;
    end
  end

  assign rd_o = mem[addr_i];
endmodule

module mips #(
  parameter bit EXEC_POSEDGE = 1'b0,
  parameter bit BYTE_IMEM    = 1'b0
) (
  input  logic clk,
  input  logic reset
);
  logic        cclk;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pcout, pc4, instruction;
  logic [31:0] add_address_out, sel_mux_1_out, jump_address;
  logic [31:0] sel_mux_2_out, mux_datamem_out;
  logic [31:0] alu_out, rd1, rd2, sext_imm, dmem_rdata;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wreg;
  logic        zeroflag;
  logic [3:0]  ALUConOut;
  logic        RegDst, Jump, Branch, MemToReg;
  logic        ALUSrc, MemWrite, RegWrite;
  logic [1:0]  ALUOp;

  // All state commits on the rising edge of cclk.
  assign cclk = EXEC_POSEDGE ? clk : ~clk;

  always_ff @(posedge cclk) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign pcout = pc_q;

  mips_imem #(.BYTE_IMEM(BYTE_IMEM)) instr_mem (
    .waddr_i (pcout[9:2]),
    .instr_o (instruction)
  );

  assign opcode   = instruction[31:26];
  assign rs       = instruction[25:21];
  assign rt       = instruction[20:16];
  assign rd       = instruction[15:11];
  assign funct    = instruction[5:0];
  assign sext_imm = {{16{instruction[15]}}, instruction[15:0]};

  always_comb begin
    RegDst   = 1'b0;
    Jump     = 1'b0;
    Branch   = 1'b0;
    MemToReg = 1'b0;
    ALUSrc   = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    ALUOp    = 2'b00;
    case (opcode)
      6'b000000: begin
        RegDst = 1'b1; RegWrite = 1'b1; ALUOp = 2'b10;
      end
      6'b100011: begin
        ALUSrc = 1'b1; MemToReg = 1'b1; RegWrite = 1'b1;
      end
      6'b101011: begin
        ALUSrc = 1'b1; MemWrite = 1'b1;
      end
      6'b000100: begin
        Branch = 1'b1; ALUOp = 2'b01;
      end
      6'b001000: begin
        ALUSrc = 1'b1; RegWrite = 1'b1;
      end
      6'b000010: Jump = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ALUConOut = 4'b0010;
    case (ALUOp)
      2'b01: ALUConOut = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100010: ALUConOut = 4'b0110;
          6'b100100: ALUConOut = 4'b0000;
          6'b100101: ALUConOut = 4'b0001;
          6'b101010: ALUConOut = 4'b0111;
          default:   ALUConOut = 4'b0010;
        endcase
      end
      default: ;
    endcase
  end

  assign wreg = RegDst ? rd : rt;

  mips_regfile reg_bank (
    .clk   (cclk),
    .reset (reset),
    .we_i  (RegWrite),
    .ra1_i (rs),
    .ra2_i (rt),
    .wa_i  (wreg),
    .wd_i  (mux_datamem_out),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  assign sel_mux_2_out = ALUSrc ? sext_imm : rd2;

  always_comb begin
    alu_out = rd1 + sel_mux_2_out;
    case (ALUConOut)
      4'b0110: alu_out = rd1 - sel_mux_2_out;
      4'b0000: alu_out = rd1 & sel_mux_2_out;
      4'b0001: alu_out = rd1 | sel_mux_2_out;
      4'b0111: alu_out = {31'd0, $signed(rd1) < $signed(sel_mux_2_out)};
      default: ;
    endcase
  end

  assign zeroflag = (alu_out == 32'd0);

  mips_dmem dat_mem (
    .clk    (cclk),
    .reset  (reset),
    .we_i   (MemWrite),
    .addr_i (alu_out[9:2]),
    .wd_i   (rd2),
    .rd_o   (dmem_rdata)
  );

  assign mux_datamem_out = MemToReg ? dmem_rdata : alu_out;

  assign pc4             = pcout + 32'd4;
  assign add_address_out = pc4 + {sext_imm[29:0], 2'b00};
  assign sel_mux_1_out   = (Branch & zeroflag) ? add_address_out : pc4;
  assign jump_address    = {pc4[31:28], instruction[25:0], 2'b00};
  assign pc_d            = Jump ? jump_address : sel_mux_1_out;
endmodule

// File: tb/tb_mips.sv
// Bench for mips: two instances (negedge/word imem and posedge/byte imem)
// run the same programs against an instruction-level model.
module tb_mips;
  logic clk = 1'b0;
  logic reset = 1'b1;

  mips #(.EXEC_POSEDGE(1'b0), .BYTE_IMEM(1'b0)) dut (
    .clk   (clk),
    .reset (reset)
  );

  mips #(.EXEC_POSEDGE(1'b1), .BYTE_IMEM(1'b1)) dut_b (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_pc;
  logic [31:0] m_reg  [32];
  logic [31:0] m_dmem [256];
  logic [31:0] m_imem [256];
  logic [31:0] s_reg  [32];
  logic [31:0] s_mem  [256];

  function automatic logic [31:0] enc_r(int s, int t, int d, logic [5:0] fn);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int s, int t,
                                        logic [15:0] imm);
    return {op, 5'(s), 5'(t), imm};
  endfunction

  function automatic logic [31:0] enc_j(logic [25:0] tg);
    return {6'd2, tg};
  endfunction

  task automatic load(input int i, input logic [31:0] w);
    m_imem[i] = w;
    dut.instr_mem.mem[i] = w;
    for (int k = 0; k < 4; k++) dut_b.instr_mem.mem[i * 4 + k] = w[k * 8 +: 8];
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) load(i, 32'd0);
  endtask

  task automatic m_reset();
    m_pc = '0;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    for (int i = 0; i < 256; i++) m_dmem[i] = '0;
  endtask

  task automatic m_wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_reg[r] = v;
  endtask

  // Executes one instruction at the instruction-set level.
  task automatic m_step();
    logic [31:0] w, a, b, imm, ea, npc, res;
    w   = m_imem[m_pc[9:2]];
    a   = m_reg[w[25:21]];
    b   = m_reg[w[20:16]];
    imm = {{16{w[15]}}, w[15:0]};
    ea  = a + imm;
    npc = m_pc + 32'd4;
    case (w[31:26])
      6'd0: begin
        case (w[5:0])
          6'd34:   res = a - b;
          6'd36:   res = a & b;
          6'd37:   res = a | b;
          6'd42:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: res = a + b;
        endcase
        m_wr(w[15:11], res);
      end
      6'd35: m_wr(w[20:16], m_dmem[ea[9:2]]);
      6'd43: m_dmem[ea[9:2]] = b;
      6'd4:  if (a == b) npc = npc + (imm << 2);
      6'd8:  m_wr(w[20:16], ea);
      6'd2:  npc = {npc[31:28], w[25:0], 2'b00};
      default: ;
    endcase
    m_pc = npc;
  endtask

  function automatic logic [9:0] m_ctrl(logic [5:0] op);
    case (op)
      6'd0:    return 10'b1000001_10;
      6'd35:   return 10'b0001101_00;
      6'd43:   return 10'b0000110_00;
      6'd4:    return 10'b0010000_01;
      6'd8:    return 10'b0000101_00;
      6'd2:    return 10'b0100000_00;
      default: return 10'b0000000_00;
    endcase
  endfunction

  function automatic logic [3:0] m_aluctl(logic [31:0] w);
    if (w[31:26] == 6'd4) return 4'b0110;
    if (w[31:26] != 6'd0) return 4'b0010;
    case (w[5:0])
      6'd34:   return 4'b0110;
      6'd36:   return 4'b0000;
      6'd37:   return 4'b0001;
      6'd42:   return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic lit(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cmp_state(input string nm, input logic [31:0] pc);
    int bad;
    lit({nm, " pcout"}, pc, m_pc);
    bad = -1;
    for (int i = 0; i < 32; i++)
      if (s_reg[i] !== m_reg[i] && bad < 0) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s reg[%0d]: got %h want %h", nm, bad, s_reg[bad], m_reg[bad]);
    end
    bad = -1;
    for (int i = 0; i < 256; i++)
      if (s_mem[i] !== m_dmem[i] && bad < 0) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s dmem[%0d]: got %h want %h", nm, bad, s_mem[bad], m_dmem[bad]);
    end
  endtask

  task automatic cmp_ctrl(input string nm, input logic [31:0] ins,
                          input logic [9:0] ctl, input logic [3:0] alc,
                          input logic z);
    logic [31:0] w;
    w = m_imem[m_pc[9:2]];
    lit({nm, " instruction"}, ins, w);
    lit({nm, " controls"}, {22'd0, ctl}, {22'd0, m_ctrl(w[31:26])});
    lit({nm, " ALUConOut"}, {28'd0, alc}, {28'd0, m_aluctl(w)});
    if (w[31:26] == 6'd4)
      lit({nm, " zeroflag"}, {31'd0, z},
          {31'd0, m_reg[w[25:21]] == m_reg[w[20:16]]});
  endtask

  task automatic check_all();
    for (int i = 0; i < 32; i++) s_reg[i] = dut.reg_bank.registers[i];
    for (int i = 0; i < 256; i++) s_mem[i] = dut.dat_mem.mem[i];
    cmp_state("A", dut.pcout);
    cmp_ctrl("A", dut.instruction,
             {dut.RegDst, dut.Jump, dut.Branch, dut.MemToReg, dut.ALUSrc,
              dut.MemWrite, dut.RegWrite, dut.ALUOp},
             dut.ALUConOut, dut.zeroflag);
    for (int i = 0; i < 32; i++) s_reg[i] = dut_b.reg_bank.registers[i];
    for (int i = 0; i < 256; i++) s_mem[i] = dut_b.dat_mem.mem[i];
    cmp_state("B", dut_b.pcout);
    cmp_ctrl("B", dut_b.instruction,
             {dut_b.RegDst, dut_b.Jump, dut_b.Branch, dut_b.MemToReg,
              dut_b.ALUSrc, dut_b.MemWrite, dut_b.RegWrite, dut_b.ALUOp},
             dut_b.ALUConOut, dut_b.zeroflag);
  endtask

  // One cycle: B commits on the posedge, A on the following negedge.
  task automatic tick();
    if (reset) m_reset();
    else       m_step();
    @(negedge clk);
    #1;
    check_all();
  endtask

  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  fns [6];
    logic [15:0] off;
    int s, t, d;
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
    fns[5] = 6'($urandom);
    s = $urandom_range(0, 7);
    t = $urandom_range(0, 7);
    d = $urandom_range(0, 7);
    case ($urandom_range(0, 9))
      0, 1: return enc_r(s, t, d, fns[$urandom_range(0, 5)]);
      2:    return enc_i(6'd8, s, t, 16'($urandom));
      3, 9: return enc_i(6'd8, s, t, 16'($urandom_range(0, 40)) - 16'd20);
      4:    return enc_i(6'd35, s, t, 16'($urandom_range(0, 255) * 4));
      5:    return enc_i(6'd43, s, t, 16'($urandom_range(0, 255) * 4));
      6: begin
        off = 16'($urandom_range(0, 8)) - 16'd4;
        return enc_i(6'd4, s, t, off);
      end
      7:    return enc_j(26'($urandom_range(0, 63)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    clear_imem();
    restart();
    lit("reset pcout", dut.pcout, 32'd0);
    lit("reset pcout B", dut_b.pcout, 32'd0);

    // Arithmetic sequence
    load(0, enc_i(6'd8, 0, 1, 16'd5));
    load(1, enc_i(6'd8, 0, 2, 16'hFFFD));
    load(2, enc_r(1, 2, 3, 6'd32));
    load(3, enc_r(1, 2, 4, 6'd34));
    load(4, enc_r(2, 1, 5, 6'd42));
    restart();
    repeat (5) tick();
    lit("add $3", dut.reg_bank.registers[3], 32'd2);
    lit("sub $4", dut.reg_bank.registers[4], 32'd8);
    lit("slt $5", dut.reg_bank.registers[5], 32'd1);
    lit("arith pcout", dut.pcout, 32'd20);
    lit("arith $3 B", dut_b.reg_bank.registers[3], 32'd2);
    lit("model $4", m_reg[4], 32'd8);

    // Store then load
    clear_imem();
    load(0, enc_i(6'd8, 0, 1, 16'h00AB));
    load(1, enc_i(6'd43, 0, 1, 16'd8));
    load(2, enc_i(6'd35, 0, 6, 16'd8));
    restart();
    tick();
    lit("sw RegWrite", {31'd0, dut.RegWrite}, 32'd0);
    lit("sw MemWrite", {31'd0, dut.MemWrite}, 32'd1);
    repeat (2) tick();
    lit("sw dmem[2]", dut.dat_mem.mem[2], 32'hAB);
    lit("lw $6", dut.reg_bank.registers[6], 32'hAB);
    lit("lw $6 B", dut_b.reg_bank.registers[6], 32'hAB);

    // Branches
    clear_imem();
    load(0, enc_i(6'd4, 0, 0, 16'd2));
    restart();
    lit("beq zeroflag", {31'd0, dut.zeroflag}, 32'd1);
    tick();
    lit("beq taken pcout", dut.pcout, 32'd12);
    lit("model beq pc", m_pc, 32'd12);
    load(0, enc_i(6'd8, 0, 1, 16'd5));
    load(1, enc_i(6'd4, 1, 0, 16'd2));
    restart();
    repeat (2) tick();
    lit("beq not taken pcout", dut.pcout, 32'd8);

    // Jump and write to $0
    clear_imem();
    load(0, enc_j(26'h10));
    load(16, enc_i(6'd8, 0, 0, 16'd7));
    restart();
    tick();
    lit("j pcout", dut.pcout, 32'h40);
    lit("j pcout B", dut_b.pcout, 32'h40);
    tick();
    lit("$0 stays 0", dut.reg_bank.registers[0], 32'd0);

    // Random programs with occasional mid-run reset
    for (int p = 0; p < 6; p++) begin
      clear_imem();
      for (int i = 0; i < 64; i++) load(i, rand_instr());
      restart();
      for (int c = 0; c < 300; c++) begin
        reset = ($urandom_range(0, 79) == 0);
        tick();
      end
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
